// File: rtl/seg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg_pkg                                                       |
// | Desc     : Shared widths, slot types and side-select constants.          |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package seg_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 4;

    typedef logic [NUM_DIGITS-1:0]       side_t;
    typedef logic [BCD_W-1:0]            bcd_t;
    typedef logic [1:0]                  slot_t;
    typedef logic [NUM_DIGITS*BCD_W-1:0] digits_t;

    localparam side_t S0       = 4'b0001;
    localparam side_t S1       = 4'b0010;
    localparam side_t S2       = 4'b0100;
    localparam side_t S3       = 4'b1000;
    localparam side_t SIDE_OFF = 4'b0000;

    function automatic side_t side_of(input slot_t idx);
        case (idx)
            2'd0:    return S0;
            2'd1:    return S1;
            2'd2:    return S2;
            default: return S3;
        endcase
    endfunction

    function automatic bcd_t digit_at(input digits_t d, input slot_t idx);
        case (idx)
            2'd0:    return d[3:0];
            2'd1:    return d[7:4];
            2'd2:    return d[11:8];
            default: return d[15:12];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : scan_prescaler                                                |
// | Desc     : Free-running 0..DIV-1 counter; tick marks the last count.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module scan_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int               c_cnt_w = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIV - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // With DIV=1 the counter is pinned at zero, so tick stays high.
    assign tick = (r_cnt == c_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : seg_scan                                                      |
// | Desc     : Tear-free four-digit display scanner. Optional leading-zero   |
// |            blanking of side is enabled by defining LEAD_ZERO_BLANK_EN.   |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module seg_scan
    import seg_pkg::*;
#(
    parameter int DIV = 50000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_DIGITS*BCD_W-1:0]  digits_in,
    input  logic                         load,
    output logic [NUM_DIGITS-1:0]        side,
    output logic [BCD_W-1:0]             num_now,
    output logic                         frame
);

    logic    w_tick;
    logic    w_wrap;
    slot_t   r_idx;
    slot_t   w_idx_next;
    digits_t r_staging;
    digits_t r_shadow;
    digits_t w_shadow_next;
    logic    r_pending;
    side_t   w_side_next;
    bcd_t    w_num_next;

    scan_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    assign w_wrap     = w_tick && (r_idx == 2'd3);
    assign w_idx_next = r_idx + 2'd1;

    // A load landing on the wrap edge goes straight to the shadow so the
    // new frame starts with it.
    always_comb begin
        w_shadow_next = r_shadow;
        if (w_wrap) begin
            if (load) begin
                w_shadow_next = digits_in;
            end else if (r_pending) begin
                w_shadow_next = r_staging;
            end
        end
    end

    assign w_num_next = digit_at(w_shadow_next, w_idx_next);

`ifdef LEAD_ZERO_BLANK_EN
    always_comb begin
        w_side_next = side_of(w_idx_next);
        case (w_idx_next)
            2'd3: if (w_shadow_next[15:12] == 4'd0) w_side_next = SIDE_OFF;
            2'd2: if (w_shadow_next[15:8]  == 8'd0) w_side_next = SIDE_OFF;
            2'd1: if (w_shadow_next[15:4]  == 12'd0) w_side_next = SIDE_OFF;
            default: ;
        endcase
    end
`else
    assign w_side_next = side_of(w_idx_next);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= 2'd0;
            side    <= S0;
            num_now <= '0;
            frame   <= 1'b0;
        end else begin
            frame <= w_wrap;
            if (w_tick) begin
                r_idx   <= w_idx_next;
                side    <= w_side_next;
                num_now <= w_num_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_staging <= '0;
            r_shadow  <= '0;
            r_pending <= 1'b0;
        end else begin
            r_shadow <= w_shadow_next;
            if (w_wrap) begin
                r_pending <= 1'b0;
            end else if (load) begin
                r_staging <= digits_in;
                r_pending <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_seg_scan                                                   |
// | Desc     : Self-checking bench for seg_scan (DIV=4 and DIV=1 instances). |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_seg_scan;

    localparam int DIV   = 4;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] digits_in;
    logic        load;
    logic [3:0]  side;
    logic [3:0]  num_now;
    logic        frame;

    logic [15:0] digits1 = 16'h0;
    logic        load1   = 1'b0;
    logic [3:0]  side1;
    logic [3:0]  num1;
    logic        frame1;

    always #5 clk = ~clk;

    seg_scan #(.DIV(DIV)) u_dut (
        .clk(clk), .rst_n(rst_n), .digits_in(digits_in), .load(load),
        .side(side), .num_now(num_now), .frame(frame)
    );

    seg_scan #(.DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .digits_in(digits1), .load(load1),
        .side(side1), .num_now(num1), .frame(frame1)
    );

    typedef struct {
        logic [3:0] side;
        logic [3:0] num;
        logic       frame;
        string      tag;
    } exp_t;

    typedef struct {
        string       name;
        int          la;
        logic [15:0] va;
        int          lb;
        logic [15:0] vb;
        logic [15:0] nxt;
    } vec_t;

    exp_t q[$];
    vec_t tbl[8];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   div1_done = 1'b0;

    task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_side(input int slot, input logic [15:0] d);
        logic [3:0] s;
        s = 4'(1 << slot);
`ifdef LEAD_ZERO_BLANK_EN
        if (slot == 3 && d[15:12] == 4'd0) s = 4'b0000;
        if (slot == 2 && d[15:8]  == 8'd0) s = 4'b0000;
        if (slot == 1 && d[15:4]  == 12'd0) s = 4'b0000;
`endif
        return s;
    endfunction

    always @(negedge clk) begin : p_mon
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            cmp({e.tag, ".side"},  {12'h0, side},    {12'h0, e.side});
            cmp({e.tag, ".num"},   {12'h0, num_now}, {12'h0, e.num});
            cmp({e.tag, ".frame"}, {15'h0, frame},   {15'h0, e.frame});
        end
    end

    // Called at posedge+1: queue what the DUT shows now, set up the next edge.
    task automatic run_frame(input logic [15:0] shown, input bit first,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input int ncyc, input string tag);
        exp_t e;
        int   slot;
        for (int p = 0; p < ncyc; p++) begin
            slot    = p / DIV;
            e.side  = exp_side(slot, shown);
            e.num   = 4'((shown >> (4 * slot)) & 16'hF);
            e.frame = (p == 0) && !first;
            e.tag   = $sformatf("%s.p%0d", tag, p);
            q.push_back(e);
            load      = (p == la) || (p == lb);
            digits_in = (p == lb) ? vb : va;
            @(posedge clk);
            #1;
            load = 1'b0;
        end
    endtask

    initial begin : p_div1
        @(posedge rst_n);
        for (int p = 0; p < 12; p++) begin
            @(negedge clk);
            cmp($sformatf("div1.side.p%0d", p), {12'h0, side1}, {12'h0, exp_side(p % 4, 16'h0)});
            cmp($sformatf("div1.frame.p%0d", p), {15'h0, frame1}, {15'h0, (p % 4 == 0) && (p > 0)});
            cmp($sformatf("div1.num.p%0d", p), {12'h0, num1}, 16'h0);
        end
        div1_done = 1'b1;
    end

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    initial begin : p_main
        logic [15:0] shown;
        tbl[0] = '{"idle",     -1, 16'h0000, -1, 16'h0000, 16'h0000};
        tbl[1] = '{"mid",       6, 16'h1234, -1, 16'h0000, 16'h1234};
        tbl[2] = '{"two",       2, 16'h1111,  9, 16'h5678, 16'h5678};
        tbl[3] = '{"wrap",     15, 16'h9999, -1, 16'h0000, 16'h9999};
        tbl[4] = '{"b0045",     5, 16'h0045, -1, 16'h0000, 16'h0045};
        tbl[5] = '{"b0405",     5, 16'h0405, -1, 16'h0000, 16'h0405};
        tbl[6] = '{"b0000",     5, 16'h0000, -1, 16'h0000, 16'h0000};
        tbl[7] = '{"restore",  10, 16'h1234, -1, 16'h0000, 16'h1234};

        rst_n = 1'b0; load = 1'b0; digits_in = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        cmp("rst.side",  {12'h0, side},    16'h0001);
        cmp("rst.num",   {12'h0, num_now}, 16'h0000);
        cmp("rst.frame", {15'h0, frame},   16'h0000);
        rst_n = 1'b1;

        shown = 16'h0;
        for (int i = 0; i < 8; i++) begin
            run_frame(shown, i == 0, tbl[i].la, tbl[i].va, tbl[i].lb, tbl[i].vb, FRAME, tbl[i].name);
            shown = tbl[i].nxt;
        end

        // Into slot s2 with a pending load, then asynchronous reset.
        run_frame(shown, 1'b0, 3, 16'h7777, -1, 16'h0, 9, "pre_rst");
        cmp("pre_rst.side", {12'h0, side}, {12'h0, exp_side(2, shown)});
        rst_n = 1'b0;
        #1;
        cmp("async_rst.side",  {12'h0, side},    16'h0001);
        cmp("async_rst.num",   {12'h0, num_now}, 16'h0000);
        cmp("async_rst.frame", {15'h0, frame},   16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(16'h0, 1'b1, -1, 16'h0, -1, 16'h0, FRAME, "post_rst0");
        run_frame(16'h0, 1'b0, -1, 16'h0, -1, 16'h0, FRAME, "post_rst1");

        @(negedge clk);
        cmp("queue_drained", 16'(q.size()), 16'h0);
        cmp("div1_done", {15'h0, div1_done}, 16'h1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Upstream stage of the seven-segment decoder in the clock design.
- Takes four BCD digits from the timekeeping logic and time-multiplexes them onto the shared display.
- Outputs a one-hot digit select (side) and the BCD digit for the active slot (num_now); the decoder consumes both directly.
- Double-buffers the digits so that a display frame never mixes old and new values (tear-free).

Parameters:
- DIV, 50000, clk cycles per digit slot (scan tick period); legal range >= 1.

Ports:
- clk  input  1  system clock (only clock).
- rst_n  input  1  asynchronous, active-low reset.
- digits_in  input  16  four BCD digits; [3:0]=digit0 (rightmost, slot s0) ... [15:12]=digit3.
- load  input  1  single-cycle strobe; capture digits_in this cycle.
- side  output  4  registered one-hot digit select: s0=0001, s1=0010, s2=0100, s3=1000; 0000 = slot blanked.
- num_now  output  4  registered BCD digit for the current slot.
- frame  output  1  registered one-cycle pulse when the slot index wraps 3->0.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values (applied immediately on rst_n low, including mid-frame): prescaler cnt=0, idx=0, side=0001, num_now=0, frame=0, staging=0, shadow=0, pending=0.
- Prescaler: cnt counts 0..DIV-1 and wraps to 0. tick=1 when cnt==DIV-1. With DIV=1, tick is high every cycle.
- Slot index: on tick, idx<=idx+1 mod 4. No change without tick.
- Output registers: on tick, side and num_now load the values for the new idx, so both change on the same edge. Each slot is held exactly DIV cycles.
  - side=1<<idx_next.
  - num_now=shadow_next[4*idx_next+:4].
- frame: high for exactly the one cycle following the tick where idx wraps 3->0. It is coincident with side becoming 0001.
- Buffering:
  - load=1: staging<=digits_in, pending<=1.
  - Multiple loads within a frame: last wins.
  - At the wrapping tick (idx==3 && tick): if pending, shadow<=staging and pending<=0.
  - load in that same wrapping cycle bypasses staging: shadow<=digits_in, pending<=0. Slot 0 of the new frame then shows the new digit.
- Mid-frame loads never alter shadow, so the current frame always completes with old values.
- Digit values 10..15 pass through unchanged; the decoder owns their interpretation.
- No handshake back-pressure; load is always accepted.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- Defined (blanking applies to the registered side only; num_now still carries the digit value):
  - Slot 3 is blanked (side=0000) if digit3==0.
  - Slot 2 is blanked if digit3 and digit2 are both 0.
  - Slot 1 is blanked if digits 3..1 are all 0.
  - Slot 0 is never blanked.
- Not defined: every slot is always driven; side is always one-hot.

Decomposition:
- Package seg_pkg:
  - side constants S0..S3 (0001, 0010, 0100, 1000) and SIDE_OFF=0000.
  - BCD_W=4, NUM_DIGITS=4.
- Sub-module scan_prescaler:
  - parameter DIV.
  - ports clk, rst_n, tick.
  - Implements the cnt counter and tick generation.
- Top handles idx, buffering, output registers and blanking.

Test Plan (DIV=4 unless noted):
- Reset then release, no load -> side cycles 0001,0010,0100,1000, each held 4 cycles; num_now=0 throughout; frame pulses every 16 cycles.
- load with digits_in=16'h1234 mid-frame -> remainder of current frame shows 0. After the wrap: slot s0 num_now=4, s1=3, s2=2, s3=1.
- Two loads in one frame (16'h1111, then 16'h5678) -> next frame shows 8,7,6,5; 1 never appears.
- load 16'h9999 in the exact wrapping cycle -> on the next edge side=0001, num_now=9, frame=1.
- rst_n pulsed low during slot s2 -> side=0001 and num_now=0 asynchronously. Buffered digits are lost; the display resumes at 0 after release.
- Blanking, run with LEAD_ZERO_BLANK_EN defined:
  - 16'h0045 -> slots 2 and 3 show side=0000.
  - 16'h0405 -> only slot 3 blanked; slot 1 shows side=0010, num_now=0.
  - 16'h0000 -> only slot 0 is driven.
- Same blanking stimulus without the macro -> all four slots are driven.
- DIV=1 -> side changes every cycle and frame pulses every 4 cycles.
